// File: rtl/lfsr_checker.sv
// Receive-side checker for the 5-bit LFSR test pattern (s[n+5] = s[n] ^ s[n+2]).
// Synchronises to the serial stream, then counts bit errors against a free-running reference.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    FILL,
    SEARCH,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_COUNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_THRESH);

  state_t           state, state_n;
  logic [4:0]       h, h_n;
  logic [4:0]       r, r_n;
  logic [2:0]       fill_cnt, fill_cnt_n;
  logic [7:0]       match_cnt, match_cnt_n;
  logic [3:0]       miss_cnt, miss_cnt_n;
  logic             locked_n;
  logic             err_pulse_n;
  logic [CNT_W-1:0] err_count_n;
  logic             ph;
  logic             pr;

  assign ph = h[0] ^ h[2];
  assign pr = r[0] ^ r[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      h         <= '0;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      r         <= r_n;
      fill_cnt  <= fill_cnt_n;
      match_cnt <= match_cnt_n;
      miss_cnt  <= miss_cnt_n;
      locked    <= locked_n;
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    h_n         = h;
    r_n         = r;
    fill_cnt_n  = fill_cnt;
    match_cnt_n = match_cnt;
    miss_cnt_n  = miss_cnt;
    locked_n    = locked;
    err_pulse_n = 1'b0;
    err_count_n = err_count;

    if (in_valid) begin
      h_n = {in_bit, h[4:1]};
      case (state)
        FILL: begin
          if (fill_cnt == 3'd4) begin
            state_n    = SEARCH;
            fill_cnt_n = '0;
          end else begin
            fill_cnt_n = fill_cnt + 3'd1;
          end
        end
        SEARCH: begin
          // An all-zero history is excluded so a stuck-at-0 line can never lock.
          if ((in_bit == ph) && (h != '0)) begin
            if (match_cnt == LOCK_LIM - 8'd1) begin
              state_n     = LOCKED;
              locked_n    = 1'b1;
              r_n         = h_n;
              match_cnt_n = '0;
              miss_cnt_n  = '0;
            end else begin
              match_cnt_n = match_cnt + 8'd1;
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          r_n = {pr, r[4:1]};
          if (in_bit != pr) begin
            err_pulse_n = 1'b1;
            if (err_count != '1) begin
              err_count_n = err_count + 1'b1;
            end
            if (miss_cnt == LOSS_LIM - 4'd1) begin
              state_n     = SEARCH;
              locked_n    = 1'b0;
              match_cnt_n = '0;
              miss_cnt_n  = '0;
            end else begin
              miss_cnt_n = miss_cnt + 4'd1;
            end
          end else begin
            miss_cnt_n = '0;
          end
        end
        default: state_n = FILL;
      endcase
    end

    // Clear wins over a coincident count, but the strobe above is left intact.
    if (clr_count) begin
      err_count_n = '0;
    end
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 5-bit LFSR pattern stream (recurrence s[n+5] = s[n] XOR s[n+2], period 31, generator output = lfsr[0] each cycle). It synchronises to an incoming bit stream, then runs its own reference LFSR to count bit errors and report lock status. It sits at the receive end of the LFSR test link, opposite the pattern generator.

## Interface
- LOCK_COUNT, 8: consecutive correct predictions in SEARCH needed to lock (1..255).
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that drop lock (1..15).
- CNT_W, 16: error counter width.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is sampled on this edge.
- in_bit  in  1  received serial pattern bit.
- clr_count  in  1  synchronous clear of err_count.
- locked  out  1  checker synchronised.
- err_pulse  out  1  one-cycle strobe per counted mismatch.
- err_count  out  CNT_W  saturating count of mismatches while locked.

## Operation
- History h[4:0]: on every valid bit, h <= {in_bit, h[4:1]}. h[0] is the oldest bit and h[4] the newest. Prediction from history is ph = h[0]^h[2].
- Reference r[4:0] (LOCKED only): pr = r[0]^r[2]. On every valid bit, r <= {pr, r[4:1]}. The reference free-runs and received bits never alter it.
- States:
  - FILL: shift the first 5 valid bits into h, with no comparisons. After the 5th bit, go to SEARCH.
  - SEARCH: on each valid bit, match = (in_bit == ph) && (h != 0), using h before the shift. On a match, match_cnt++; otherwise match_cnt = 0. When match_cnt reaches LOCK_COUNT: r <= the post-shift h (including the current bit), go to LOCKED, and set locked = 1 at the same edge.
  - LOCKED: on each valid bit, mismatch = (in_bit != pr). On a mismatch: err_pulse = 1, err_count++ (saturating), miss_cnt++. On a match, miss_cnt = 0. When miss_cnt reaches LOSS_THRESH (this mismatch is still counted): go to SEARCH, locked = 0, match_cnt = 0, miss_cnt = 0. h keeps shifting and is not cleared.
- An all-zero history never produces a match, so a stuck-at-0 stream never locks.
- No comparisons or counting happen outside LOCKED, so err_count changes only in LOCKED.
- err_count saturates at 2^CNT_W-1; a further mismatch still pulses err_pulse.
- clr_count has priority: if it coincides with a mismatch, err_count becomes 0 (the mismatch is not counted), but err_pulse still asserts.
- in_valid low: no state changes anywhere, and err_pulse = 0.

## Timing
- All outputs are registered and update on the edge that samples in_valid/in_bit. Latency is 1 clock from the sampling edge to visibility.
- Reset values: state FILL, h = 0, r = 0, match_cnt = 0, miss_cnt = 0, locked = 0, err_pulse = 0, err_count = 0. rst overrides every input, including mid-lock.
- err_pulse is high for exactly the cycle after each counted mismatch, so back-to-back mismatches give back-to-back pulses.
- Earliest lock: after the (5 + LOCK_COUNT)th valid bit, which is the 13th by default.
- Loss of lock: locked falls on the edge sampling the LOSS_THRESHth consecutive mismatch.
- Relock after loss: at most 5 + LOCK_COUNT valid bits of a clean stream.
- Throughput: one bit per clock, with no back-pressure.

## Test plan
- Clean lock: rst, then a continuous valid stream from a generator seeded 5'b00001 -> locked rises after the 13th bit; err_count stays 0 across 200 bits and err_pulse never fires.
- Single error: after lock, invert 1 bit -> one err_pulse one cycle later, err_count = 1, locked stays 1, and the following bits produce no further errors.
- Loss and relock: after lock, invert 4 consecutive bits -> err_count = 4, locked falls on the 4th; a clean stream then relocks within 13 bits with err_count held at 4.
- Degenerate input: an all-zero stream for 100 bits, then an all-one stream for 100 bits -> locked stays 0 and err_count stays 0 for both.
- Gapped valid: the clean stream with in_valid toggled pseudo-randomly -> lock occurs on the 13th valid bit, and the state is unchanged during gaps.
- Counter edges: CNT_W = 4 with 20 isolated errors -> err_count saturates at 15 while pulses continue; assert clr_count coincident with an error -> err_count = 0 and err_pulse = 1. Assert rst mid-lock -> all outputs 0 and state FILL.
